// File: rtl/wide_add_sequencer.sv
// Adds two WORDS*W-bit operands one word per step through a shared external W-bit adder.
// The adder has no carry-in, so an incoming word carry costs a second pass that adds 1.
module wide_add_sequencer #(
  parameter int W     = 16,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [W*WORDS-1:0]   a_in,
  input  logic [W*WORDS-1:0]   b_in,
  input  logic                 cin,
  output logic [W-1:0]         adder_a,
  output logic [W-1:0]         adder_b,
  input  logic [W-1:0]         adder_sum,
  input  logic                 adder_cout,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [W*WORDS-1:0]   sum_out,
  output logic                 cout_out,
  output logic                 busy
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [W*WORDS-1:0]   a_q, a_d;
  logic [W*WORDS-1:0]   b_q, b_d;
  logic [W*WORDS-1:0]   sum_q, sum_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 carry_q, carry_d;
  logic [W-1:0]         partial_q, partial_d;
  logic                 pc_q, pc_d;
  logic [W*WORDS-1:0]   sum_out_q, sum_out_d;
  logic                 cout_out_q, cout_out_d;
  logic                 advance_s;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      partial_q  <= '0;
      pc_q       <= 1'b0;
      sum_out_q  <= '0;
      cout_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      partial_q  <= partial_d;
      pc_q       <= pc_d;
      sum_out_q  <= sum_out_d;
      cout_out_q <= cout_out_d;
    end
  end

  // Next-state, word sequencing and adder operand selection.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    partial_d  = partial_q;
    pc_d       = pc_q;
    sum_out_d  = sum_out_q;
    cout_out_d = cout_out_q;
    adder_a    = '0;
    adder_b    = '0;
    advance_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADD: begin
        adder_a = a_q[idx_q*W +: W];
        adder_b = b_q[idx_q*W +: W];
        if (carry_q) begin
          partial_d = adder_sum;
          pc_d      = adder_cout;
          state_d   = S_FIX;
        end else begin
          sum_d[idx_q*W +: W] = adder_sum;
          carry_d             = adder_cout;
          advance_s           = 1'b1;
        end
      end
      S_FIX: begin
        // Second pass folds the incoming carry in; pc and this cout are mutually exclusive.
        adder_a             = partial_q;
        adder_b             = W'(1);
        sum_d[idx_q*W +: W] = adder_sum;
        carry_d             = pc_q | adder_cout;
        advance_s           = 1'b1;
      end
      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (advance_s) begin
      if (idx_q == LAST_IDX) begin
        state_d    = S_DONE;
        sum_out_d  = sum_d;
        cout_out_d = carry_d;
      end else begin
        idx_d   = idx_q + IW'(1);
        state_d = S_ADD;
      end
    end else begin
      idx_d = idx_d;
    end
  end

  assign start_ready  = (state_q == S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign busy         = (state_q == S_ADD) || (state_q == S_FIX);
  assign sum_out      = sum_out_q;
  assign cout_out     = cout_out_q;

endmodule
